// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, fetch funct3 and FSM state encoding for mem_arbiter.
package mem_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [2:0] FUNCT3_LW = 3'b010;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2,
    DONE      = 2'd3
  } state_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access, data first.
// Define MEM_ARB_FAIR_EN to bound instruction starvation to STARVE_MAX consecutive data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef MEM_ARB_FAIR_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inst_req,
  input  logic [XLEN-1:0] i_inst_addr,
  output logic            or_inst_ack,
  output logic [XLEN-1:0] or_inst_data,
  input  logic            i_data_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_wdata,
  input  logic [2:0]      i_data_funct3,
  input  logic            i_data_we,
  output logic            or_data_ack,
  output logic [XLEN-1:0] or_data_rdata,
  output logic            or_mem_req,
  output logic [XLEN-1:0] or_mem_addr,
  output logic [XLEN-1:0] or_mem_wdata,
  output logic [2:0]      or_mem_funct3,
  output logic            or_mem_we,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic              mem_we_q, mem_we_d;
  logic              inst_ack_q, inst_ack_d;
  logic [XLEN-1:0]   inst_data_q, inst_data_d;
  logic              data_ack_q, data_ack_d;
  logic [XLEN-1:0]   data_rdata_q, data_rdata_d;
  logic              inst_first;
  logic              grant_data;
  logic              grant_inst;

  assign grant_data = i_data_req && !(i_inst_req && inst_first);
  assign grant_inst = i_inst_req && !grant_data;

`ifdef MEM_ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign inst_first = starve_q == CW'(STARVE_MAX);

  // Counts data grants that overtook a waiting fetch; saturates at STARVE_MAX.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && grant_inst)
      starve_d = '0;
    else if (state_q == IDLE && grant_data && i_inst_req && !inst_first)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign inst_first = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    mem_we_d     = mem_we_q;
    inst_ack_d   = 1'b0;
    inst_data_d  = inst_data_q;
    data_ack_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d      = DATA_BUSY;
          mem_req_d    = 1'b1;
          mem_addr_d   = i_data_addr;
          mem_wdata_d  = i_data_wdata;
          mem_funct3_d = i_data_funct3;
          mem_we_d     = i_data_we;
        end else if (grant_inst) begin
          state_d      = INST_BUSY;
          mem_req_d    = 1'b1;
          mem_addr_d   = i_inst_addr;
          mem_wdata_d  = '0;
          mem_funct3_d = FUNCT3_LW;
          mem_we_d     = 1'b0;
        end
      end
      INST_BUSY, DATA_BUSY: begin
        if (i_mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (state_q == INST_BUSY) begin
            inst_ack_d  = 1'b1;
            inst_data_d = i_mem_rdata;
          end else begin
            data_ack_d   = 1'b1;
            data_rdata_d = mem_we_q ? data_rdata_q : i_mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      mem_we_q     <= 1'b0;
      inst_ack_q   <= 1'b0;
      inst_data_q  <= '0;
      data_ack_q   <= 1'b0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      mem_we_q     <= mem_we_d;
      inst_ack_q   <= inst_ack_d;
      inst_data_q  <= inst_data_d;
      data_ack_q   <= data_ack_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign or_mem_req    = mem_req_q;
  assign or_mem_addr   = mem_addr_q;
  assign or_mem_wdata  = mem_wdata_q;
  assign or_mem_funct3 = mem_funct3_q;
  assign or_mem_we     = mem_we_q;
  assign or_inst_ack   = inst_ack_q;
  assign or_inst_data  = inst_data_q;
  assign or_data_ack   = data_ack_q;
  assign or_data_rdata = data_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_data;
  logic        data_req;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [2:0]  data_funct3;
  logic        data_we;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  int vectors = 0;
  int miscompares = 0;

  mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr),
    .or_inst_ack(inst_ack), .or_inst_data(inst_data),
    .i_data_req(data_req), .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .i_data_funct3(data_funct3), .i_data_we(data_we),
    .or_data_ack(data_ack), .or_data_rdata(data_rdata),
    .or_mem_req(mem_req), .or_mem_addr(mem_addr), .or_mem_wdata(mem_wdata),
    .or_mem_funct3(mem_funct3), .or_mem_we(mem_we),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] order;
    logic [6:0] exp_order;
    logic       was_inst;
    int         data_n;
    int         waited;
    rst_n = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_addr = '0;
    data_wdata = '0; data_funct3 = '0; data_we = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_acks", {30'b0, inst_ack, data_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ctrl", {28'b0, mem_funct3, mem_we}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // instruction fetch alone
    inst_req = 1'b1; inst_addr = 32'h0000_0010;
    tick();
    chk("if_mem_req", {31'b0, mem_req}, 32'd1);
    chk("if_mem_addr", mem_addr, 32'h10);
    chk("if_funct3", {29'b0, mem_funct3}, 32'd2);
    chk("if_we", {31'b0, mem_we}, 32'd0);
    chk("if_wdata", mem_wdata, 32'd0);
    tick(); tick();
    chk("if_wait_req", {31'b0, mem_req}, 32'd1);
    chk("if_wait_ack", {31'b0, inst_ack}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0051_0093;
    tick();
    mem_ack = 1'b0; inst_req = 1'b0;
    chk("if_ack", {31'b0, inst_ack}, 32'd1);
    chk("if_data", inst_data, 32'h0051_0093);
    chk("if_no_data_ack", {31'b0, data_ack}, 32'd0);
    chk("if_req_drop", {31'b0, mem_req}, 32'd0);
    tick();
    chk("if_ack_pulse", {31'b0, inst_ack}, 32'd0);
    chk("if_data_hold", inst_data, 32'h0051_0093);

    // collision: data wins, fetch follows after DONE
    inst_req = 1'b1; inst_addr = 32'h20;
    data_req = 1'b1; data_addr = 32'h1000; data_we = 1'b0; data_funct3 = 3'b010;
    tick();
    chk("col_first_addr", mem_addr, 32'h1000);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 1'b0; data_req = 1'b0;
    chk("col_data_ack", {30'b0, inst_ack, data_ack}, 32'd1);
    chk("col_rdata", data_rdata, 32'hCAFE_0001);
    tick();
    chk("col_done_no_grant", {31'b0, mem_req}, 32'd0);
    tick();
    chk("col_inst_req", {31'b0, mem_req}, 32'd1);
    chk("col_inst_addr", mem_addr, 32'h20);
    chk("col_inst_funct3", {29'b0, mem_funct3}, 32'd2);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; inst_req = 1'b0;
    chk("col_inst_ack", {30'b0, inst_ack, data_ack}, 32'd2);
    chk("col_inst_data", inst_data, 32'h1111_2222);
    tick();

    // store
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h2004; data_wdata = 32'hDEAD_BEEF; data_funct3 = 3'b001;
    tick();
    chk("st_addr", mem_addr, 32'h2004);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_ctrl", {28'b0, mem_funct3, mem_we}, 32'b0011);
    data_addr = 32'h9999; data_wdata = 32'h0;
    tick();
    chk("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_hold_addr", mem_addr, 32'h2004);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0; data_req = 1'b0; data_we = 1'b0;
    chk("st_ack", {30'b0, inst_ack, data_ack}, 32'd1);
    chk("st_rdata_kept", data_rdata, 32'hCAFE_0001);
    tick();

    // stalled memory
    data_req = 1'b1; data_addr = 32'h3000; data_funct3 = 3'b100;
    tick();
    inst_req = 1'b1; inst_addr = 32'h44; data_addr = 32'h0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("stall_req", {31'b0, mem_req}, 32'd1);
      chk("stall_fields", {mem_addr[27:0], mem_funct3, mem_we}, {28'h000_3000, 3'b100, 1'b0});
      chk("stall_acks", {30'b0, inst_ack, data_ack}, 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 1'b0; data_req = 1'b0; inst_req = 1'b0;
    chk("stall_ack", {30'b0, inst_ack, data_ack}, 32'd1);
    chk("stall_rdata", data_rdata, 32'h77);
    tick();

    // reset in the middle of a transaction
    data_req = 1'b1; data_addr = 32'h4000; data_funct3 = 3'b010;
    tick();
    chk("rmt_req", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0; data_req = 1'b0;
    tick();
    chk("rmt_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rmt_addr", mem_addr, 32'd0);
    chk("rmt_rdata", data_rdata, 32'd0);
    chk("rmt_inst_data", inst_data, 32'd0);
    chk("rmt_acks", {30'b0, inst_ack, data_ack}, 32'd0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("rmt_stray_ack", {30'b0, inst_ack, data_ack}, 32'd0);
    chk("rmt_idle_req", {31'b0, mem_req}, 32'd0);
    chk("rmt_rdata_kept", data_rdata, 32'd0);
    tick();

    // fetch held while six data requests stream in
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_addr = 32'h5000; data_we = 1'b0;
    data_n = 0; order = '0;
    for (int g = 0; g < 7; g++) begin
      waited = 0;
      while (!mem_req && waited < 10) begin
        tick();
        waited++;
      end
      if (!mem_req) begin
        chk("arb_grant_timeout", {31'b0, mem_req}, 32'd1);
        break;
      end
      was_inst = mem_addr == 32'h40;
      order[g] = was_inst;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("arb_owner_ack", {30'b0, inst_ack, data_ack}, was_inst ? 32'd2 : 32'd1);
      if (was_inst) inst_req = 1'b0;
      else begin
        data_n++;
        data_addr = data_addr + 32'd4;
        if (data_n == 6) data_req = 1'b0;
      end
    end
`ifdef MEM_ARB_FAIR_EN
    exp_order = 7'b001_0000;
`else
    exp_order = 7'b100_0000;
`endif
    chk("arb_order", {25'b0, order}, {25'b0, exp_order});
    inst_req = 1'b0; data_req = 1'b0;
    tick(); tick();
    chk("arb_quiet", {31'b0, mem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port between the CPU fetch-stage instruction port and the memory-stage data port.
- Sits between the cpu top-level request/ack pins and the single-ported memory controller (BRAM/DDR2 bridge).
- Serves one transaction at a time; data requests have priority by default.
- A compile-time fairness option bounds instruction-side starvation.

Parameters:
- XLEN, 32, width of addresses and data (`XLEN from header.vh)
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits (used only with MEM_ARB_FAIR_EN)

Ports:
- i_clk  input  1  CPU clock
- i_rst_n  input  1  reset; one clock; reset is synchronous and active-low
- i_inst_req  input  1  instruction request, level, held until o_inst_ack
- i_inst_addr  input  XLEN  instruction address, stable while i_inst_req
- or_inst_ack  output  1  one-cycle completion pulse to fetch
- or_inst_data  output  XLEN  fetched word, valid with or_inst_ack
- i_data_req  input  1  data request, level, held until or_data_ack
- i_data_addr  input  XLEN  data address
- i_data_wdata  input  XLEN  store data
- i_data_funct3  input  3  byte/half/word and sign (RV32I load/store funct3)
- i_data_we  input  1  0 = read, 1 = write
- or_data_ack  output  1  one-cycle completion pulse to memory stage
- or_data_rdata  output  XLEN  load data, valid with or_data_ack on reads
- or_mem_req  output  1  request to memory, held until i_mem_ack
- or_mem_addr  output  XLEN  latched address
- or_mem_wdata  output  XLEN  latched store data
- or_mem_funct3  output  3  latched funct3; 3'b010 for instruction fetches
- or_mem_we  output  1  latched write enable; 0 for fetches
- i_mem_ack  input  1  memory completion pulse
- i_mem_rdata  input  XLEN  memory read data, valid with i_mem_ack

Behaviour:
- All outputs are registered.
- Reset (i_rst_n = 0 at a clock edge) returns the FSM to IDLE and clears every output to 0, including the data and address buses.
- Reset mid-transaction abandons it: or_mem_req drops, and no ack is issued. The memory controller must tolerate a withdrawn request.
- FSM states: IDLE, INST_BUSY, DATA_BUSY, DONE.
- IDLE:
  - If i_data_req is high: latch addr/wdata/funct3/we, set or_mem_req = 1, go to DATA_BUSY.
  - Else if i_inst_req is high: latch i_inst_addr, funct3 = 3'b010, we = 0, wdata = 0, set or_mem_req = 1, go to INST_BUSY.
  - Both high at once: data wins (it is the older instruction), unless overridden by the fairness option.
- *_BUSY:
  - Hold or_mem_req and all latched fields stable.
  - Ignore the requester inputs; requests cannot be withdrawn once granted.
  - On i_mem_ack: or_mem_req = 0, pulse the owner's ack for exactly one cycle, go to DONE.
  - On a read, capture i_mem_rdata into or_inst_data / or_data_rdata at the same edge.
  - On a write, or_data_rdata keeps its previous value.
- DONE:
  - Acks return to 0; no grant this cycle; go to IDLE.
  - The requester must drop req on the edge after it sees ack.
- Latency:
  - Request sampled at edge N gives or_mem_req high after edge N.
  - i_mem_ack at edge M gives the requester ack high for the cycle after edge M.
  - Minimum gap between request start and ack is 2 cycles.
  - Back-to-back grants are separated by one DONE cycle.
- Data outputs hold their last value until the next capture; they are not cleared on ack fall.
- An i_mem_ack seen in IDLE or DONE is ignored.
- At most one of or_inst_ack / or_data_ack is high in any cycle.

Optional Feature:
- MEM_ARB_FAIR_EN defined:
  - A starvation counter (width $clog2(STARVE_MAX+1)) increments on each data grant made while i_inst_req is high.
  - When the counter equals STARVE_MAX and both requests are pending in IDLE, the instruction request is granted instead.
  - The counter clears on any instruction grant and on reset. It saturates and never wraps.
- MEM_ARB_FAIR_EN undefined:
  - Strict data priority; no counter logic is generated.

Decomposition:
- Add FSM state encodings (2-bit: IDLE=0, INST_BUSY=1, DATA_BUSY=2, DONE=3) and `FUNCT3_LW 3'b010 to header.vh alongside `XLEN.
- No sub-module needed: the FSM, capture registers and optional counter live in one module.

Test Plan:
- Inst only: i_inst_req = 1, addr 0x0000_0010; memory acks 3 cycles later with 0x0051_0093 -> or_mem_funct3 = 3'b010, or_mem_we = 0; or_inst_ack pulses 1 cycle with or_inst_data = 0x0051_0093; or_data_ack stays 0.
- Collision: inst (0x20) and data read (0x1000) asserted the same cycle -> data granted first; the inst grant starts only after DONE; the two acks are in separate cycles.
- Store: data write addr 0x2004, wdata 0xDEAD_BEEF, funct3 3'b001 -> or_mem_* match exactly while or_mem_req is high; or_data_rdata unchanged after ack.
- Reset mid-transaction: assert i_rst_n = 0 during DATA_BUSY -> next cycle or_mem_req = 0 and all outputs 0; no ack pulse; a later i_mem_ack in IDLE is ignored.
- Fairness (MEM_ARB_FAIR_EN, STARVE_MAX = 4): hold i_inst_req high and give 6 continuous data requests -> the 5th grant goes to inst; without the macro all 6 data requests complete before inst.
- Stall memory: i_mem_ack held low for 50 cycles -> or_mem_req and the latched fields stay constant; no acks are issued.
